// File: rtl/divider_seq_if.sv
// Handshake and operand/result bundle for divider_seq.
// master: requester (drives start and operands); slave: the divider.
interface divider_seq_if #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
);
  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      busy;
  logic                      done;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_seq.sv
// divider_seq: sequential radix-2 restoring unsigned divider, one quotient
// bit per clock, start/done handshake, registered quotient/remainder.
// Optional build macro DIVIDER_SEQ_ROUND_EN: round-half-up quotient
// (saturating) on completion; remainder stays truncated.
module divider_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  divider_seq_if.slave bus
);
  localparam int W  = DIVIDEND_WIDTH;
  localparam int D  = DIVISOR_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  // The dividend shift register doubles as the quotient accumulator: each
  // iteration shifts out a dividend bit at the top and a quotient bit in at
  // the bottom, so after W iterations it holds the full quotient.
  logic [W-1:0]   dsr_q;
  // Partial remainder is kept to D bits: it is always < divisor between
  // iterations, so the (D+1)-th bit only exists transiently in rem_shift.
  logic [D-1:0]   rem_q;
  logic [D-1:0]   dvs_q;

  logic [W-1:0]   q_out_q;
  logic [D-1:0]   r_out_q;
  logic           dz_out_q;

  logic           accept;
  logic           zero_div;
  logic           last_iter;
  logic [D:0]     rem_shift;
  logic           q_bit;
  logic [D-1:0]   rem_iter;
  logic [W-1:0]   q_raw;
  logic [W-1:0]   q_final;

`ifdef DIVIDER_SEQ_ROUND_EN
  // Round half up: bump the quotient when 2*rem >= divisor, saturating.
  function automatic logic [W-1:0] round_q(input logic [W-1:0] q,
                                           input logic [D-1:0] r,
                                           input logic [D-1:0] d);
    if (({r, 1'b0} >= {1'b0, d}) && (q != {W{1'b1}}))
      return q + W'(1);
    return q;
  endfunction
`endif

  // One restoring iteration: shift in next dividend bit, trial-subtract.
  always_comb begin
    rem_shift = {rem_q, dsr_q[W-1]};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
    // True result is < divisor, so D-bit modular subtraction is exact.
    rem_iter  = q_bit ? (rem_shift[D-1:0] - dvs_q) : rem_shift[D-1:0];
    q_raw     = {dsr_q[W-2:0], q_bit};
`ifdef DIVIDER_SEQ_ROUND_EN
    q_final   = round_q(q_raw, rem_iter, dvs_q);
`else
    q_final   = q_raw;
`endif
  end

  // Next-state logic; start is honoured in IDLE and DONE only.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    zero_div  = (bus.divisor == '0);
    last_iter = (cnt_q == CW'(W - 1));
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = zero_div ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC:    if (last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and result registers (reset to zero).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_out_q  <= '0;
      r_out_q  <= '0;
      dz_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == CALC)
        cnt_q <= cnt_q + CW'(1);
      if (accept && zero_div) begin
        q_out_q  <= '1;
        r_out_q  <= bus.dividend[D-1:0];
        dz_out_q <= 1'b1;
      end else if (state_q == CALC && last_iter) begin
        q_out_q  <= q_final;
        r_out_q  <= rem_iter;
        dz_out_q <= 1'b0;
      end
    end
  end

  // Iteration datapath; operands are only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      dsr_q <= bus.dividend;
      dvs_q <= bus.divisor;
      rem_q <= '0;
    end else if (state_q == CALC) begin
      dsr_q <= q_raw;
      rem_q <= rem_iter;
    end
  end

  // busy excludes the first CALC cycle so it spans W-1 cycles before done.
  assign bus.busy        = (state_q == CALC) && (cnt_q != '0);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = q_out_q;
  assign bus.remainder   = r_out_q;
  assign bus.div_by_zero = dz_out_q;
endmodule

// File: tb/tb_divider_seq.sv
// Testbench for divider_seq: directed scenarios plus randomized operations,
// all checked against a plain-arithmetic reference model.
module tb_divider_seq;
  localparam int W = 32;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_seq_if #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(D)) bus ();

  divider_seq #(.DIVIDEND_WIDTH(W), .DIVISOR_WIDTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference: integer division with the zero-divisor convention.
  function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dz);
    logic [31:0] r32;
    if (b == 16'd0) begin
      q = 32'hFFFF_FFFF; r = a[15:0]; dz = 1'b1;
    end else begin
      q   = a / {16'd0, b};
      r32 = a % {16'd0, b};
      r   = r32[15:0];
      dz  = 1'b0;
`ifdef DIVIDER_SEQ_ROUND_EN
      if ((64'(r) * 2 >= 64'(b)) && (q != 32'hFFFF_FFFF)) q = q + 32'd1;
`endif
    end
  endfunction

  // Must be called at a negedge; start is sampled by the following posedge.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // lat = index of the negedge (0 = first one after the start edge) seeing done.
  task automatic wait_done(output int lat, output int busy_n, output bit ok);
    lat = -1; busy_n = 0; ok = 1'b0;
    for (int j = 0; j < 64 && !ok; j++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin lat = j; ok = 1'b1; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else passes++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else passes++;
    checks++; if (bus.quotient !== 32'd0) $display("FAIL reset_q got=%h want=0", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 16'd0) $display("FAIL reset_r got=%h want=0", bus.remainder); else passes++;
    checks++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dz got=%b want=0", bus.div_by_zero); else passes++;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL rst_beats_start busy=%b done=%b want 0/0", bus.busy, bus.done); else passes++;
  endtask

  task automatic test_basic();
    int lat, bn; bit ok;
    @(negedge clk);
    start_op(32'd100, 16'd7);
    wait_done(lat, bn, ok);
    checks++; if (!ok) $display("FAIL basic_timeout no done"); else passes++;
    checks++; if (lat != 32) $display("FAIL basic_latency got=%0d want=32", lat); else passes++;
    checks++; if (bn != 31) $display("FAIL basic_busy_cycles got=%0d want=31", bn); else passes++;
    checks++; if (bus.quotient !== 32'd14) $display("FAIL basic_q got=%0d want=14", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 16'd2) $display("FAIL basic_r got=%0d want=2", bus.remainder); else passes++;
    checks++; if (bus.div_by_zero !== 1'b0) $display("FAIL basic_dz got=%b want=0", bus.div_by_zero); else passes++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width got=%b want=0", bus.done); else passes++;
    checks++; if (bus.quotient !== 32'd14) $display("FAIL basic_q_hold got=%0d want=14", bus.quotient); else passes++;
  endtask

  task automatic test_div_zero();
    int lat, bn; bit ok;
    @(negedge clk);
    start_op(32'd1234, 16'd0);
    wait_done(lat, bn, ok);
    checks++; if (!ok || lat != 0) $display("FAIL dz_latency got=%0d want=0", lat); else passes++;
    checks++; if (bn != 0) $display("FAIL dz_busy got=%0d want=0", bn); else passes++;
    checks++; if (bus.quotient !== 32'hFFFF_FFFF) $display("FAIL dz_q got=%h want=ffffffff", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 16'h04D2) $display("FAIL dz_r got=%h want=04d2", bus.remainder); else passes++;
    checks++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag got=%b want=1", bus.div_by_zero); else passes++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1)
      $display("FAIL dz_after done=%b dz=%b want 0/1", bus.done, bus.div_by_zero); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit ok;
    logic [31:0] eq; logic [15:0] er; logic edz;
    @(negedge clk);
    start_op(32'hFFFF_FFFF, 16'hFFFF);
    wait_done(lat, bn, ok);
    checks++; if (!ok || bus.quotient !== 32'h0001_0001)
      $display("FAIL b2b_first_q got=%h want=00010001", bus.quotient); else passes++;
    checks++; if (bus.remainder !== 16'd0) $display("FAIL b2b_first_r got=%h want=0", bus.remainder); else passes++;
    // Still in the DONE cycle: issue the next request immediately.
    start_op(32'd5, 16'd9);
    wait_done(lat, bn, ok);
    ref_div(32'd5, 16'd9, eq, er, edz);
    checks++; if (!ok || lat != 32) $display("FAIL b2b_latency got=%0d want=32", lat); else passes++;
    checks++; if (bus.quotient !== eq) $display("FAIL b2b_q got=%0d want=%0d", bus.quotient, eq); else passes++;
    checks++; if (bus.remainder !== er) $display("FAIL b2b_r got=%0d want=%0d", bus.remainder, er); else passes++;
  endtask

  task automatic test_start_ignored();
    int first, dcnt;
    logic [31:0] gq, eq; logic [15:0] gr, er; logic edz;
    first = -1; dcnt = 0; gq = '0; gr = '0;
    @(negedge clk);
    start_op(32'd50, 16'd3);
    for (int j = 0; j < 72; j++) begin
      @(negedge clk);
      if (j == 10) begin
        bus.start = 1'b1; bus.dividend = 32'd99; bus.divisor = 16'd1;
      end else if (j == 11) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dcnt++;
        if (first < 0) begin first = j; gq = bus.quotient; gr = bus.remainder; end
      end
    end
    ref_div(32'd50, 16'd3, eq, er, edz);
    checks++; if (first != 32) $display("FAIL ign_latency got=%0d want=32", first); else passes++;
    checks++; if (dcnt != 1) $display("FAIL ign_done_count got=%0d want=1", dcnt); else passes++;
    checks++; if (gq !== eq) $display("FAIL ign_q got=%0d want=%0d", gq, eq); else passes++;
    checks++; if (gr !== er) $display("FAIL ign_r got=%0d want=%0d", gr, er); else passes++;
  endtask

  task automatic test_rst_abort();
    int lat, bn, dcnt; bit ok;
    logic [31:0] eq; logic [15:0] er; logic edz;
    @(negedge clk);
    start_op(32'd1000, 16'd10);
    for (int j = 0; j < 12; j++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL abort_ctrl busy=%b done=%b want 0/0", bus.busy, bus.done); else passes++;
    checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 16'd0 || bus.div_by_zero !== 1'b0)
      $display("FAIL abort_outputs q=%h r=%h dz=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero); else passes++;
    dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
    end
    checks++; if (dcnt != 0) $display("FAIL abort_no_done active_cycles=%0d want=0", dcnt); else passes++;
    start_op(32'd1000, 16'd10);
    wait_done(lat, bn, ok);
    ref_div(32'd1000, 16'd10, eq, er, edz);
    checks++; if (!ok || bus.quotient !== eq) $display("FAIL abort_retry_q got=%0d want=%0d", bus.quotient, eq); else passes++;
    checks++; if (bus.remainder !== er) $display("FAIL abort_retry_r got=%0d want=%0d", bus.remainder, er); else passes++;
  endtask

  task automatic test_round();
    int lat, bn; bit ok;
    logic [31:0] want_q;
`ifdef DIVIDER_SEQ_ROUND_EN
    want_q = 32'd13;
`else
    want_q = 32'd12;
`endif
    @(negedge clk);
    start_op(32'd100, 16'd8);
    wait_done(lat, bn, ok);
    checks++; if (!ok || bus.quotient !== want_q) $display("FAIL round_q got=%0d want=%0d", bus.quotient, want_q); else passes++;
    checks++; if (bus.remainder !== 16'd4) $display("FAIL round_r got=%0d want=4", bus.remainder); else passes++;
  endtask

  task automatic test_random();
    int lat, bn; bit ok;
    logic [31:0] a, eq; logic [15:0] b, er; logic edz;
    @(negedge clk);
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      if (($urandom & 3) == 0) a = $urandom_range(0, 300);
      case ($urandom_range(0, 4))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      ref_div(a, b, eq, er, edz);
      start_op(a, b);
      wait_done(lat, bn, ok);
      checks++; if (!ok || lat != ((b == 16'd0) ? 0 : 32))
        $display("FAIL rand_latency a=%h b=%h got=%0d", a, b, lat); else passes++;
      checks++; if (bus.quotient !== eq)
        $display("FAIL rand_q a=%h b=%h got=%h want=%h", a, b, bus.quotient, eq); else passes++;
      checks++; if (bus.remainder !== er || bus.div_by_zero !== edz)
        $display("FAIL rand_r a=%h b=%h got=%h/%b want=%h/%b", a, b, bus.remainder, bus.div_by_zero, er, edz); else passes++;
      // Randomly either chain in the DONE cycle or idle a few cycles.
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0; rst = 1'b1;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_start_ignored();
    test_rst_abort();
    test_round();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
